// File: rtl/lab1_imul_resp_accum.sv
// rtl/lab1_imul_resp_accum.sv - groups multiplier products into modulo-2^32 sums
//
// Sums every p_nterms accepted products and emits one sum message per group.
// out_ovf flags that at least one unsigned carry out of bit 31 happened while
// building the group.
//
// Ports:
//   clk      - clock, rising edge
//   reset    - asynchronous active-high reset
//   clear    - synchronous abort of the current group
//   in_val   - product valid
//   in_rdy   - accumulator can take a product
//   in_msg   - 32-bit product
//   out_val  - group sum valid
//   out_rdy  - sink accepts the sum
//   out_msg  - group sum modulo 2^32
//   out_ovf  - carry-out seen in this group, qualified by out_val

module lab1_imul_resp_accum #(
  parameter int p_nterms = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_val,
  output logic        in_rdy,
  input  logic [31:0] in_msg,
  output logic        out_val,
  input  logic        out_rdy,
  output logic [31:0] out_msg,
  output logic        out_ovf
);

  generate
    if (p_nterms < 1 || p_nterms > 255) begin : g_bad_nterms
      $error("lab1_imul_resp_accum: p_nterms must be in 1..255");
    end
  endgenerate

  localparam int CW = $clog2(p_nterms + 1);
  // Count value held before the transfer that completes the group.
  localparam logic [CW-1:0] LAST = CW'(p_nterms - 1);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_DONE  = 1'b1;

  logic [0:0]    state;
  logic [31:0]   sum;
  logic          ovf;
  logic [CW-1:0] cnt;

  logic          in_xfer;
  logic          out_xfer;
  logic [32:0]   sum_wide;

  // Handshake outputs are pure functions of the state register, so no
  // combinational path exists from in_val/out_rdy to the other side.
  assign in_rdy   = (state == ST_ACCUM);
  assign out_val  = (state == ST_DONE);
  assign out_msg  = sum;
  assign out_ovf  = ovf;

  assign in_xfer  = in_val && in_rdy;
  assign out_xfer = out_val && out_rdy;

  // 33-bit add: bit 32 is the unsigned carry out of the 32-bit sum.
  assign sum_wide = {1'b0, sum} + {1'b0, in_msg};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_ACCUM;
      sum   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else if (clear) begin
      // Any transfer completing in this cycle is discarded.
      state <= ST_ACCUM;
      sum   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (in_xfer) begin
            sum <= sum_wide[31:0];
            ovf <= ovf | sum_wide[32];
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              state <= ST_DONE;
            end
          end
        end
        default: begin
          if (out_xfer) begin
            state <= ST_ACCUM;
            sum   <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lab1_imul_resp_accum.sv
// tb/tb_lab1_imul_resp_accum.sv - directed self-checking bench for lab1_imul_resp_accum

module tb_lab1_imul_resp_accum;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  // p_nterms = 4 instance
  logic        clear = 1'b0;
  logic        in_val = 1'b0;
  logic        in_rdy;
  logic [31:0] in_msg = '0;
  logic        out_val;
  logic        out_rdy = 1'b1;
  logic [31:0] out_msg;
  logic        out_ovf;

  // p_nterms = 1 instance
  logic        clear1 = 1'b0;
  logic        in_val1 = 1'b0;
  logic        in_rdy1;
  logic [31:0] in_msg1 = '0;
  logic        out_val1;
  logic        out_rdy1 = 1'b1;
  logic [31:0] out_msg1;
  logic        out_ovf1;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  lab1_imul_resp_accum #(.p_nterms(4)) dut4 (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_msg  (in_msg),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_msg (out_msg),
    .out_ovf (out_ovf)
  );

  lab1_imul_resp_accum #(.p_nterms(1)) dut1 (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear1),
    .in_val  (in_val1),
    .in_rdy  (in_rdy1),
    .in_msg  (in_msg1),
    .out_val (out_val1),
    .out_rdy (out_rdy1),
    .out_msg (out_msg1),
    .out_ovf (out_ovf1)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one product to the 4-term instance and hold it until accepted.
  task automatic send(input logic [31:0] v);
    int guard;
    in_val = 1'b1;
    in_msg = v;
    guard  = 0;
    while (!in_rdy && guard < 50) begin
      step();
      guard++;
    end
    check("send_rdy", {31'b0, in_rdy}, 32'd1);
    step();
    in_val = 1'b0;
  endtask

  task automatic send_group(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] d);
    send(a);
    send(b);
    send(c);
    send(d);
  endtask

  // Wait (bounded) for a sum, check it, and let the sink take it if out_rdy=1.
  task automatic expect_out(input string tag, input logic [31:0] msg, input logic ovf);
    int guard;
    guard = 0;
    while (!out_val && guard < 50) begin
      step();
      guard++;
    end
    check({tag, "_val"}, {31'b0, out_val}, 32'd1);
    check({tag, "_msg"}, out_msg, msg);
    check({tag, "_ovf"}, {31'b0, out_ovf}, {31'b0, ovf});
    check({tag, "_inrdy"}, {31'b0, in_rdy}, 32'd0);
    step();
  endtask

  initial begin
    #2;
    // Reset values while reset is held
    check("rst_in_rdy",  {31'b0, in_rdy},  32'd1);
    check("rst_out_val", {31'b0, out_val}, 32'd0);
    check("rst_out_msg", out_msg,          32'd0);
    check("rst_out_ovf", {31'b0, out_ovf}, 32'd0);
    step();
    reset = 1'b0;
    step();

    // Basic group: out_val exactly one cycle after the fourth transfer
    send_group(32'd1, 32'd2, 32'd3, 32'd4);
    check("basic_lat_val", {31'b0, out_val}, 32'd1);
    expect_out("basic", 32'd10, 1'b0);
    check("basic_after_val", {31'b0, out_val}, 32'd0);

    // Overflow, then ovf must clear for the next group
    send_group(32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0);
    expect_out("ovf", 32'd1, 1'b1);
    send_group(32'd5, 32'd5, 32'd5, 32'd5);
    expect_out("ovf_clr", 32'd20, 1'b0);

    // Backpressure with random source gaps
    out_rdy = 1'b0;
    send(32'd7);
    repeat ($urandom_range(0, 2)) step();
    send(32'd8);
    repeat ($urandom_range(0, 2)) step();
    send(32'd9);
    repeat ($urandom_range(0, 2)) step();
    send(32'd10);
    in_val = 1'b1;
    in_msg = 32'd100;
    for (int i = 0; i < 3; i++) begin
      check("bp_val",   {31'b0, out_val}, 32'd1);
      check("bp_msg",   out_msg,          32'd34);
      check("bp_inrdy", {31'b0, in_rdy},  32'd0);
      step();
    end
    out_rdy = 1'b1;
    expect_out("bp", 32'd34, 1'b0);
    send(32'd100);
    send(32'd0);
    send(32'd0);
    send(32'd1);
    expect_out("bp2", 32'd101, 1'b0);

    // Clear mid-group; the transfer offered during clear is dropped
    send(32'd50);
    send(32'd60);
    clear  = 1'b1;
    in_val = 1'b1;
    in_msg = 32'd99;
    step();
    clear  = 1'b0;
    in_val = 1'b0;
    check("clr_val", {31'b0, out_val}, 32'd0);
    send_group(32'd1, 32'd1, 32'd1, 32'd1);
    expect_out("clr", 32'd4, 1'b0);

    // Clear coinciding with the final transfer: no DONE
    send(32'd9);
    send(32'd9);
    send(32'd9);
    clear  = 1'b1;
    in_val = 1'b1;
    in_msg = 32'd9;
    step();
    clear  = 1'b0;
    in_val = 1'b0;
    check("clr_last_val", {31'b0, out_val}, 32'd0);
    check("clr_last_rdy", {31'b0, in_rdy},  32'd1);

    // Asynchronous reset while in DONE
    out_rdy = 1'b0;
    send_group(32'd3, 32'd3, 32'd3, 32'd3);
    check("rstd_val", {31'b0, out_val}, 32'd1);
    check("rstd_msg", out_msg,          32'd12);
    #2;
    reset = 1'b1;
    #1;
    check("rstd_drop_val", {31'b0, out_val}, 32'd0);
    check("rstd_drop_msg", out_msg,          32'd0);
    check("rstd_drop_rdy", {31'b0, in_rdy},  32'd1);
    #1;
    reset = 1'b0;
    step();
    out_rdy = 1'b1;
    send_group(32'd2, 32'd2, 32'd2, 32'd2);
    expect_out("rstd", 32'd8, 1'b0);

    // p_nterms = 1: each product is its own group
    in_val1 = 1'b1;
    in_msg1 = 32'd42;
    check("n1_rdy_a", {31'b0, in_rdy1}, 32'd1);
    step();
    in_val1 = 1'b0;
    check("n1_val_a",   {31'b0, out_val1}, 32'd1);
    check("n1_msg_a",   out_msg1,          32'd42);
    check("n1_ovf_a",   {31'b0, out_ovf1}, 32'd0);
    check("n1_inrdy_a", {31'b0, in_rdy1},  32'd0);
    step();
    check("n1_idle_a",  {31'b0, out_val1}, 32'd0);
    in_val1 = 1'b1;
    in_msg1 = 32'h8000_0000;
    check("n1_rdy_b", {31'b0, in_rdy1}, 32'd1);
    step();
    in_val1 = 1'b0;
    check("n1_val_b", {31'b0, out_val1}, 32'd1);
    check("n1_msg_b", out_msg1,          32'h8000_0000);
    check("n1_ovf_b", {31'b0, out_ovf1}, 32'd0);
    step();
    check("n1_idle_b", {31'b0, out_val1}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/lab1_imul_resp_accum.md
# lab1_imul_resp_accum

Downstream consumer of the integer multiplier's response stream. Accepts 32-bit product messages over a val/rdy interface, sums a fixed-size group of `p_nterms` products modulo 2^32, and emits one sum message per group over a second val/rdy interface. This turns the multiplier into the multiply stage of a dot-product/MAC pipeline. It also tracks unsigned carry-out so software can detect overflow.

## Interface

Parameters:
- `p_nterms`, default 4: products per group. Legal range is 1 to 255; the synthesis-time check rejects any other value.

Ports:
- `clk`, input, 1: sole clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `clear`, input, 1: synchronous abort of the current group; highest priority after `reset`.
- `in_val`, input, 1: product valid (driven by multiplier `resp_val`).
- `in_rdy`, output, 1: accumulator can accept a product (drives multiplier `resp_rdy`).
- `in_msg`, input, 32: product value (multiplier `resp_msg.result`).
- `out_val`, output, 1: group sum valid.
- `out_rdy`, input, 1: sink accepts the sum.
- `out_msg`, output, 32: group sum modulo 2^32.
- `out_ovf`, output, 1: at least one unsigned carry-out of bit 31 occurred in this group; qualified by `out_val`.

## Operation

- State machine with two states:
  - `ACCUM` (reset state): `in_rdy=1`, `out_val=0`.
  - `DONE`: `in_rdy=0`, `out_val=1`.
- Registers:
  - `sum[31:0]`.
  - `ovf`.
  - `cnt`, width `$clog2(p_nterms+1)`, counting accepted products in the current group.
- In `ACCUM`, an input transfer (`in_val && in_rdy`) does all of the following:
  - `sum <= sum + in_msg`, 32-bit wrap.
  - `ovf <= ovf | carry33`, where `carry33` is bit 32 of the 33-bit add.
  - `cnt <= cnt + 1`.
- Transition `ACCUM -> DONE` on the transfer that makes `cnt` reach `p_nterms`.
- In `DONE`:
  - `out_msg = sum` and `out_ovf = ovf`, driven directly from registers.
  - On an output transfer (`out_val && out_rdy`): `sum <= 0`, `ovf <= 0`, `cnt <= 0`, next state `ACCUM`.
- `clear`, in any state: `sum`, `ovf`, `cnt` go to 0 and the state goes to `ACCUM`. Any input or output transfer in the same cycle is discarded.
  - `in_rdy` and `out_val` stay as the state dictates.
  - Because a transfer can complete in a `clear` cycle, the sender must treat it as dropped. The bench checks this.
- `out_val` does not depend combinationally on `out_rdy`. `in_rdy` does not depend on `in_val`. No combinational in-to-out path exists.
- `p_nterms=1`: every accepted product produces one output equal to that product, with `out_ovf=0`.
- Line trace fields, in order: input val/rdy/msg, `cnt`, state char (`A`/`D`), output val/rdy/msg.

## Timing

- Reset values (asynchronous, immediate): state `ACCUM`, `sum=0`, `ovf=0`, `cnt=0`.
  - Therefore `in_rdy=1`, `out_val=0`, `out_msg=0`, `out_ovf=0`.
- Latency: `out_val` rises in the cycle after the group's final input transfer.
- Throughput with the sink always ready: one group per `p_nterms+1` cycles.
  - The `DONE` cycle is a bubble; `in_rdy=0` there even if `out_rdy=1`.
- Backpressure: while `out_rdy=0`, the block holds `DONE` with `out_msg` and `out_ovf` stable, and `in_rdy` stays 0.
- Input stalls (`in_val=0`) leave all registers unchanged; partial groups persist indefinitely.
- `reset` asserted mid-group or in `DONE` discards everything immediately; no output is produced for that group.
- Simultaneous `clear` and final input transfer: `clear` wins and no `DONE` is entered.
- Counter never exceeds `p_nterms`. Sum wraps silently, with `out_ovf` as the only indication.

## Test plan

- Basic group, `p_nterms=4`, sink ready: inputs 1, 2, 3, 4 on consecutive cycles -> `out_msg=10`, `out_ovf=0`, `out_val` one cycle after the fourth transfer, `in_rdy=0` that cycle.
- Overflow: inputs `0xFFFFFFFF`, 2, 0, 0 -> `out_msg=0x00000001`, `out_ovf=1`. The next group 5, 5, 5, 5 -> `out_msg=20`, `out_ovf=0`, confirming `ovf` clears.
- Backpressure and random source delays: two groups {7, 8, 9, 10} and {100, 0, 0, 1} with `out_rdy` held low 3 cycles -> `out_msg=34` stays stable until accepted, then 101. No input is accepted while in `DONE`.
- Clear mid-group: inputs 50, 60, then `clear`, then 1, 1, 1, 1 -> single output 4. No output of 110.
- Async reset in `DONE`: after inputs 3, 3, 3, 3, assert `reset` mid-cycle -> `out_val` drops to 0 immediately. After release, 2, 2, 2, 2 -> `out_msg=8`.
- `p_nterms=1`: inputs 42, `0x80000000` -> outputs 42 and `0x80000000`, each with `out_ovf=0`, one cycle after the corresponding transfer.
